gps_acq_correlator: RTL

- Receive-side acquisition engine for the 1-bit GPS IF stream produced by the signal generator core.
- Wipes off a locally generated carrier (sin/cos bits) and C/A replica bit from each input sample, and accumulates I and Q over one code period (dwell).
- Slips the replica by one sample per failed dwell until |I|+|Q| reaches a threshold or every phase has been tried.
- Drives the enable of an external replica path (prescaler + gold code generator) and reports the code phase found.

---
 rtl/gps_acq_correlator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gps_acq_correlator.sv
// GPS acquisition correlator.
// Takes the 1-bit IF stream and removes the local C/A replica and the local
// carrier from each sample. It integrates I and Q over one dwell, then
// evaluates |I|+|Q| against a threshold. After each failed dwell it slips the
// replica by one sample, until the threshold is met or every phase has been
// tried.
module gps_acq_correlator #(
   parameter int DWELL_LEN = 16368,
   parameter int NB_ACC    = 15,
   parameter int NB_PHASE  = 14
) (
   input  logic                clk_in,
   input  logic                rst_in_n,
   input  logic                ena_in,
   input  logic                sample_in,
   input  logic                code_in,
   input  logic                lo_sin_in,
   input  logic                lo_cos_in,
   input  logic                start_in,
   input  logic [NB_ACC:0]     threshold_in,
   output logic                code_ena_out,
   output logic                busy_out,
   output logic                done_out,
   output logic                lock_out,
   output logic [NB_PHASE-1:0] phase_out,
   output logic [NB_ACC:0]     peak_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DWELL,
      S_EVAL,
      S_SLIP,
      S_DONE
   } state_t;

   // Last sample index of a dwell, which is also the last candidate phase.
   localparam logic [NB_PHASE-1:0] LAST = NB_PHASE'(DWELL_LEN - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic signed [NB_ACC-1:0] r_acc_i;
   logic signed [NB_ACC-1:0] r_acc_q;
   logic [NB_PHASE-1:0]      r_cnt;
   logic [NB_PHASE-1:0]      r_slip;
   logic [NB_PHASE-1:0]      r_best;
   logic [NB_PHASE-1:0]      r_phase;
   logic [NB_ACC:0]          r_peak;
   logic                     r_done;
   logic                     r_lock;

   logic                     w_e;
   logic signed [NB_ACC-1:0] w_inc_i;
   logic signed [NB_ACC-1:0] w_inc_q;
   logic [NB_ACC-1:0]        w_abs_i;
   logic [NB_ACC-1:0]        w_abs_q;
   logic [NB_ACC:0]          w_mag;
   logic                     w_new_peak;
   logic                     w_lock_hit;
   logic [NB_PHASE-1:0]      w_best_nxt;
   logic                     w_code_ena;
   logic                     w_busy;

   // Code and carrier wipe-off: a match contributes +1 and a mismatch contributes -1.
   assign w_e     = sample_in ^ code_in;
   assign w_inc_i = (w_e ^ lo_sin_in) ? {NB_ACC{1'b1}} : NB_ACC'(1);
   assign w_inc_q = (w_e ^ lo_cos_in) ? {NB_ACC{1'b1}} : NB_ACC'(1);

   // The magnitude is one bit wider than the accumulators, so the sum cannot overflow.
   // A full-scale negative accumulator still gives the correct absolute value here.
   assign w_abs_i    = r_acc_i[NB_ACC-1] ? $unsigned(-r_acc_i) : $unsigned(r_acc_i);
   assign w_abs_q    = r_acc_q[NB_ACC-1] ? $unsigned(-r_acc_q) : $unsigned(r_acc_q);
   assign w_mag      = {1'b0, w_abs_i} + {1'b0, w_abs_q};
   // A strict compare means ties keep the earlier phase.
   assign w_new_peak = (w_mag > r_peak);
   assign w_lock_hit = (w_mag >= threshold_in);
   assign w_best_nxt = w_new_peak ? r_slip : r_best;

   // State register.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_in_n) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state logic, plus the outputs that decode the current state.
   always_comb begin
      // NOTE: defaults come first so that no path leaves a signal unassigned, which would infer a latch.
      w_state_nxt = r_state;
      w_code_ena  = ena_in;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start_in) w_state_nxt = S_DWELL;
         end
         S_DWELL: begin
            w_busy = 1'b1;
            if (ena_in && (r_cnt == LAST)) w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            w_busy = 1'b1;
            if (w_lock_hit || (r_slip == LAST)) w_state_nxt = S_DONE;
            else                                w_state_nxt = S_SLIP;
         end
         S_SLIP: begin
            w_busy     = 1'b1;
            w_code_ena = 1'b0;
            if (ena_in) w_state_nxt = S_DWELL;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: accumulate, evaluate, slip and hold the results.
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_cnt   <= '0;
         r_slip  <= '0;
         r_best  <= '0;
         r_phase <= '0;
         r_peak  <= '0;
         r_done  <= 1'b0;
         r_lock  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start_in) begin
                  r_acc_i <= '0;
                  r_acc_q <= '0;
                  r_cnt   <= '0;
                  r_slip  <= '0;
                  r_best  <= '0;
                  r_peak  <= '0;
                  r_lock  <= 1'b0;
               end
            end
            S_DWELL: begin
               if (ena_in) begin
                  r_acc_i <= r_acc_i + w_inc_i;
                  r_acc_q <= r_acc_q + w_inc_q;
                  r_cnt   <= r_cnt + NB_PHASE'(1);
               end
            end
            S_EVAL: begin
               if (w_new_peak) begin
                  r_peak <= w_mag;
                  r_best <= r_slip;
               end
               if (w_lock_hit) begin
                  r_lock  <= 1'b1;
                  r_phase <= r_slip;
                  r_done  <= 1'b1;
               end else if (r_slip == LAST) begin
                  r_phase <= w_best_nxt;
                  r_done  <= 1'b1;
               end
            end
            S_SLIP: begin
               // The replica is held for this one strobe, which shifts it by one sample.
               if (ena_in) begin
                  r_slip  <= r_slip + NB_PHASE'(1);
                  r_acc_i <= '0;
                  r_acc_q <= '0;
                  r_cnt   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign code_ena_out = w_code_ena;
   assign busy_out     = w_busy;
   assign done_out     = r_done;
   assign lock_out     = r_lock;
   assign phase_out    = r_phase;
   assign peak_out     = r_peak;

endmodule
